shl_sched: RTL
==============

Name: shl_sched

Overview:
Sequencer/arbiter that shares one combinational SHL shifter between NREQ requesters.
- Each requester offers an operand a and a shift amount sh_amt over a valid/ready handshake.
- The block grants one requester at a time, registers its operands, and drives the shared SHL from those registers.
- It returns the result and the requester ID on a single valid/ready output port.
- It sits between the datapath's operation sources and the shared shifter resource.

Parameters:
- DATAWIDTH, 8: width of a, sh_amt and d, matching SHL.
- NREQ, 4: number of requesters, legal range 2..8.
- ID_W, derived as clog2(NREQ), minimum 1: width of out_id. Not user-overridable.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, NREQ: per-requester request valid.
- req_ready, output, NREQ: per-requester accept strobe, at most one bit high.
- req_a, input, NREQ*DATAWIDTH: packed operands; requester i uses bits [i*DATAWIDTH +: DATAWIDTH].
- req_sh_amt, input, NREQ*DATAWIDTH: packed shift amounts, same packing as req_a.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_d, output, DATAWIDTH: shifted result.
- out_id, output, ID_W: index of the requester that owns out_d.

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst_n is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=0, out_valid=0, out_d=0, out_id=0, operand registers=0, rr_ptr=NREQ-1 (so requester 0 wins first).
- Arithmetic: d = a << sh_amt, truncated to DATAWIDTH bits. Any sh_amt >= DATAWIDTH gives d=0. Vacated LSBs are zero-filled.
- State IDLE:
  - Grant g is the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready[g] is combinational from req_valid, is high in IDLE only, and is one-hot.
  - On the edge where req_valid[g]&req_ready[g]=1: capture req_a and req_sh_amt slices into op_a/op_sh, store g into id_r, set rr_ptr=g, go to SHIFT.
  - If no request is valid, stay in IDLE.
- State SHIFT (1 cycle):
  - SHL is driven by op_a/op_sh.
  - At the next edge: out_d=SHL result, out_id=id_r, out_valid=1, go to HOLD.
  - req_ready=0 throughout.
- State HOLD:
  - out_d, out_id and out_valid are held stable while out_ready=0.
  - On the edge with out_valid&out_ready: out_valid=0, go to IDLE.
  - req_ready=0 throughout.
- Latency: out_valid rises 2 edges after the accept edge. Peak throughput is 1 operation per 3 cycles.
- Backpressure: out_ready may be low indefinitely. No new grant is issued while in HOLD.
- Requester rules:
  - A requester may drop req_valid at any time before it is accepted; no grant is then issued to it.
  - Operand values are sampled only on the accept edge.
- Simultaneous events:
  - out_ready high on the same edge out_valid rises has no effect; out_ready is sampled only in HOLD.
  - A request arriving while in HOLD waits in IDLE arbitration.
- Reset mid-operation: asynchronously returns to reset values. An in-flight accepted operation is discarded without output; requesters must reissue.
- rr_ptr update rule: rr_ptr updates only on an accept, so an idle requester does not shift fairness.

Optional Feature:
- Macro SHL_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority arbitration, lowest index wins. rr_ptr is not implemented.
- Undefined: round-robin arbitration as specified in Behaviour.
- Handshake, latency and ports are identical in both builds.

Decomposition:
- Package shl_sched_pkg:
  - State enum {IDLE, SHIFT, HOLD}, 2-bit encoding.
  - clog2 function used to derive ID_W.
  - NREQ legal-range constants.
- One sub-module: the existing SHL combinational shifter, instantiated once with DATAWIDTH, inputs op_a/op_sh.
- Arbitration stays inline; it is too small to justify a separate module.

Test Plan:
1. NREQ=4, DATAWIDTH=8. Only req 0 valid, a=20, sh=1 -> req_ready[0] high 1 cycle; out_valid 2 edges after accept; out_d=40, out_id=0.
2. Req 2 sequence: a=20 sh=3, then a=40 sh=4 -> out_d=160, then out_d=128 (640 truncated); out_id=2 both times.
3. Boundary shifts: a=0xFF sh=7 -> 0x80; sh=8 -> 0x00; sh=200 -> 0x00.
4. All 4 requesters valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1. With SHL_SCHED_FIXED_PRIO_EN -> always 0.
5. Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_d and out_id stable, req_ready=0. Raise out_ready -> out_valid falls next edge, IDLE grants the next requester.
6. Reset mid-op: assert Rst_n=0 during SHIFT -> out_valid=0 and req_ready=0 immediately. After release, requester 0 is granted first and no stale result appears.

Source files
------------

// File: rtl/shl_sched_pkg.sv
// Shared types and constants for the shl_sched shifter sequencer.
// The optional build macro SHL_SCHED_FIXED_PRIO_EN is consumed in shl_sched.sv.
package shl_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  // Ceiling log2 with a floor of 1 so single-bit index ports never collapse to zero width.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shl_sched_shl.sv
// Combinational logical shift-left: d = a << sh_amt, truncated, zero-filled.
// Built as a log-depth barrel shifter with an overflow flush for large amounts.
module shl_sched_shl
  import shl_sched_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic [DATAWIDTH-1:0] d
);

  localparam int SW = clog2_min1(DATAWIDTH);

  logic [DATAWIDTH-1:0] stage [SW+1];
  logic                 overflow;

  assign stage[0] = a;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    assign stage[s+1] = sh_amt[s] ? (stage[s] << (1 << s)) : stage[s];
  end

  // Any set bit above the stage range means a shift of at least DATAWIDTH.
  assign overflow = |(sh_amt >> SW);
  assign d        = overflow ? '0 : stage[SW];

endmodule

// File: rtl/shl_sched.sv
// Arbitrated sequencer sharing one SHL shifter among NREQ valid/ready requesters.
// Define SHL_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module shl_sched
  import shl_sched_pkg::*;
#(
  parameter  int DATAWIDTH = 8,
  parameter  int NREQ      = 4,
  localparam int ID_W      = clog2_min1(NREQ)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_sh_amt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATAWIDTH-1:0]      out_d,
  output logic [ID_W-1:0]           out_id
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("shl_sched: NREQ outside the supported range");
  end

  state_t               state;
  state_t               next_state;
  logic [DATAWIDTH-1:0] op_a;
  logic [DATAWIDTH-1:0] op_sh;
  logic [DATAWIDTH-1:0] shl_d;
  logic [DATAWIDTH-1:0] sel_a;
  logic [DATAWIDTH-1:0] sel_sh;
  logic [ID_W-1:0]      id_r;
  logic [ID_W-1:0]      grant;
  logic                 grant_vld;
  logic                 accept;

`ifdef SHL_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_vld = 1'b1;
        grant     = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] idx;

  // Search starts just after the last accepted requester and wraps modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // Only an accept moves the pointer, so idle cycles never disturb fairness.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_ptr <= ID_W'(NREQ - 1);
    end else if (accept) begin
      rr_ptr <= grant;
    end
  end
`endif

  always_comb begin
    sel_a  = '0;
    sel_sh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a  = req_a[i*DATAWIDTH +: DATAWIDTH];
        sel_sh = req_sh_amt[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // req_ready is gated by Rst_n so it reads low for the whole reset window.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld && Rst_n) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          next_state       = SHIFT;
        end
      end
      SHIFT:   next_state = HOLD;
      HOLD:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stage boundary: operand capture on accept, result capture leaving SHIFT.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_a      <= '0;
      op_sh     <= '0;
      id_r      <= '0;
      out_d     <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_a  <= sel_a;
        op_sh <= sel_sh;
        id_r  <= grant;
      end
      if (state == SHIFT) begin
        out_d  <= shl_d;
        out_id <= id_r;
      end
      out_valid <= (next_state == HOLD);
    end
  end

  shl_sched_shl #(
    .DATAWIDTH(DATAWIDTH)
  ) u_shl (
    .a     (op_a),
    .sh_amt(op_sh),
    .d     (shl_d)
  );

endmodule
